// File: rtl/multicycle_adder.sv
// Chunk-serial add/subtract unit: ChunkBits per cycle with a carry register.
// Start/Busy/Done handshake; result and flags update only on completion.
module multicycle_adder #(
    parameter int NrOfBits  = 32,
    parameter int ChunkBits = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Subtract,
    input  logic                CarryIn,
    input  logic [NrOfBits-1:0] DataA,
    input  logic [NrOfBits-1:0] DataB,
    output logic                Busy,
    output logic                Done,
    output logic [NrOfBits-1:0] Result,
    output logic                CarryOut,
    output logic                Overflow,
    output logic                Zero
);

    localparam int N    = NrOfBits / ChunkBits;
    localparam int CntW = (N > 1) ? $clog2(N) : 1;
    localparam int Msb  = NrOfBits - 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic [NrOfBits-1:0] a_q, a_d;
    logic [NrOfBits-1:0] b_q, b_d;
    logic [NrOfBits-1:0] acc_q, acc_d;
    logic [NrOfBits-1:0] res_q, res_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic                done_q, done_d;

    logic [ChunkBits:0]  sum;
    int                  base;
    logic                last;

    // Next-state: operand capture on Start, one chunk per RUN cycle, commit on last chunk
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        base    = int'(cnt_q) * ChunkBits;
        last    = (cnt_q == CntW'(N - 1));
        sum     = {1'b0, a_q[base +: ChunkBits]}
                + {1'b0, b_q[base +: ChunkBits]}
                + {{ChunkBits{1'b0}}, carry_q};
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = DataA;
                    b_d     = Subtract ? ~DataB : DataB;
                    carry_d = Subtract ? 1'b1 : CarryIn;
                end
            end
            RUN: begin
                acc_d[base +: ChunkBits] = sum[ChunkBits-1:0];
                carry_d = sum[ChunkBits];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    res_d   = acc_d;
                    cout_d  = sum[ChunkBits];
                    ovf_d   = (a_q[Msb] == b_q[Msb]) && (acc_d[Msb] != a_q[Msb]);
                    zero_d  = (acc_d == '0);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign Busy     = (state_q == RUN);
    assign Done     = done_q;
    assign Result   = res_q;
    assign CarryOut = cout_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: 32/8 (N=4) and 32/32 (N=1) instances.
// Hand-computed vectors for carry, overflow, borrow, handshake and reset.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic        sub_s, cin_s;
    logic [31:0] da, db;

    logic        busy0, done0, co0, ov0, z0;
    logic [31:0] res0;
    logic        busy1, done1, co1, ov1, z1;
    logic [31:0] res1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_adder #(.NrOfBits(32), .ChunkBits(8)) u0 (
        .Clock(clk), .Reset(rst), .Start(start0), .Subtract(sub_s),
        .CarryIn(cin_s), .DataA(da), .DataB(db), .Busy(busy0),
        .Done(done0), .Result(res0), .CarryOut(co0), .Overflow(ov0),
        .Zero(z0)
    );

    multicycle_adder #(.NrOfBits(32), .ChunkBits(32)) u1 (
        .Clock(clk), .Reset(rst), .Start(start1), .Subtract(sub_s),
        .CarryIn(cin_s), .DataA(da), .DataB(db), .Busy(busy1),
        .Done(done1), .Result(res1), .CarryOut(co1), .Overflow(ov1),
        .Zero(z1)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy0"}, 64'(busy0), 64'd0);
        check({tag, ".done0"}, 64'(done0), 64'd0);
        check({tag, ".res0"}, 64'(res0), 64'd0);
        check({tag, ".flags0"}, 64'({co0, ov0, z0}), 64'd0);
        check({tag, ".busy1"}, 64'(busy1), 64'd0);
        check({tag, ".done1"}, 64'(done1), 64'd0);
        check({tag, ".res1"}, 64'(res1), 64'd0);
        check({tag, ".flags1"}, 64'({co1, ov1, z1}), 64'd0);
    endtask

    // Launch on the current (or next) negedge, check Busy for N cycles,
    // then the Done cycle with result and flags.
    task automatic do_op(input bit which, input logic [31:0] a,
                         input logic [31:0] b, input bit sub, input bit cin,
                         input logic [31:0] eres, input bit eco,
                         input bit eov, input bit ez, input string tag,
                         input bit aligned, input bit chk_held,
                         input logic [31:0] held);
        int n;
        n = which ? 1 : 4;
        if (!aligned) @(negedge clk);
        da    = a;
        db    = b;
        sub_s = sub;
        cin_s = cin;
        if (which) start1 = 1'b1;
        else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        da     = $urandom;
        db     = $urandom;
        sub_s  = 1'($urandom);
        cin_s  = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, ".busy"}, 64'(which ? busy1 : busy0), 64'd1);
            check({tag, ".nodone"}, 64'(which ? done1 : done0), 64'd0);
            if (chk_held)
                check({tag, ".held"}, 64'(which ? res1 : res0), 64'(held));
        end
        @(negedge clk);
        check({tag, ".done"}, 64'(which ? done1 : done0), 64'd1);
        check({tag, ".idle"}, 64'(which ? busy1 : busy0), 64'd0);
        check({tag, ".res"}, 64'(which ? res1 : res0), 64'(eres));
        check({tag, ".cout"}, 64'(which ? co1 : co0), 64'(eco));
        check({tag, ".ovf"}, 64'(which ? ov1 : ov0), 64'(eov));
        check({tag, ".zero"}, 64'(which ? z1 : z0), 64'(ez));
    endtask

    initial begin
        int ndone;
        int at;
        rst    = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        sub_s  = 1'b0;
        cin_s  = 1'b1;
        da     = 32'h1234_5678;
        db     = 32'h0000_0001;

        // Reset held two cycles with Start high
        @(negedge clk);
        check_zero("rst1");
        @(negedge clk);
        check_zero("rst2");
        rst    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;

        // Carry ripple and basic adds
        do_op(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1,
              "ripple", 0, 0, 0);
        do_op(0, 32'h1234_5678, 32'h1111_1111, 0, 1, 32'h2345_678A,
              0, 0, 0, "cin", 0, 0, 0);

        // Signed overflow
        do_op(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0,
              "ovf_add", 0, 0, 0);
        do_op(0, 32'h8000_0000, 32'h1, 1, 0, 32'h7FFF_FFFF, 1, 1, 0,
              "ovf_sub", 0, 0, 0);

        // Subtract borrow, CarryIn low
        do_op(0, 32'd5, 32'd7, 1, 0, 32'hFFFF_FFFE, 0, 0, 0,
              "sub5_7", 0, 0, 0);
        do_op(0, 32'd7, 32'd5, 1, 0, 32'd2, 1, 0, 0,
              "sub7_5", 0, 0, 0);
        do_op(0, 32'd9, 32'd9, 1, 0, 32'd0, 1, 0, 1,
              "sub9_9", 0, 0, 0);

        // Start while busy is ignored, one Done pulse
        @(negedge clk);
        da     = 32'd1;
        db     = 32'd2;
        sub_s  = 1'b0;
        cin_s  = 1'b0;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        da     = 32'hDEAD_BEEF;
        db     = 32'h0BAD_F00D;
        sub_s  = 1'b1;
        @(posedge clk);
        #1;
        da     = 32'h5555_5555;
        db     = 32'h1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        ndone  = 0;
        at     = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done0) begin
                ndone++;
                at = i;
                check("ign.res", 64'(res0), 64'd3);
                check("ign.flags", 64'({co0, ov0, z0}), 64'd0);
            end
        end
        check("ign.ndone", 64'(ndone), 64'd1);
        check("ign.when", 64'(at), 64'd3);

        // Back-to-back: Start in the Done cycle, old result held
        do_op(0, 32'd10, 32'd20, 0, 0, 32'h1E, 0, 0, 0,
              "b2b1", 0, 0, 0);
        do_op(0, 32'd100, 32'd1, 0, 0, 32'h65, 0, 0, 0,
              "b2b2", 1, 1, 32'h1E);

        // Reset in RUN cycle 2
        @(negedge clk);
        da     = 32'hFFFF_FFFF;
        db     = 32'hFFFF_FFFF;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check("midrst.nodone", 64'(ndone), 64'd0);
        do_op(0, 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0,
              "afterrst", 0, 0, 0);

        // Single-chunk instance
        do_op(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1,
              "n1_ripple", 0, 0, 0);
        do_op(1, 32'h8000_0000, 32'h1, 1, 0, 32'h7FFF_FFFF, 1, 1, 0,
              "n1_ovf", 0, 0, 0);
        do_op(1, 32'd5, 32'd7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0,
              "n1_sub", 1, 1, 32'h7FFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
